// File: rtl/rggen_local_bus_splitter.sv
// Purpose: local-bus responder. Decodes one host command to a one-hot register select, waits for
//          that register's ready (bounded by a timeout) and returns a one-cycle response.
//          Decode misses and timeouts are answered locally with error status 01.
// Latency: hit = 2 + ready-wait cycles; miss = 1 cycle; timeout = TIMEOUT_CYCLES + 1 cycles.
// Backpressure: one command in flight. i_command_valid is sampled only in IDLE and is held by the host
//          until o_response_ready. Register-side stalls are bounded by the timeout counter.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_command_valid/i_write/i_read    host command strobe and direction
//   i_address/i_write_data/i_write_mask  host byte address, write data and bitwise write enable
//   o_response_ready/o_read_data/o_status  single-cycle response (status 00 OK, 01 error)
//   o_register_select/_write/_read    one-hot select and qualifiers, driven only during ACCESS
//   o_register_write_data/_mask       latched write data and mask, driven only during ACCESS
//   i_register_ready/_read_data/_status  packed per-register completion, read data and status
module rggen_local_bus_splitter #(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int REGISTERS           = 4,
    parameter int TIMEOUT_CYCLES      = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_command_valid,
    input  logic                            i_write,
    input  logic                            i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH-1:0]           i_write_data,
    input  logic [DATA_WIDTH-1:0]           i_write_mask,
    output logic                            o_response_ready,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic [1:0]                      o_status,
    output logic [REGISTERS-1:0]            o_register_select,
    output logic                            o_register_write,
    output logic                            o_register_read,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH-1:0]           o_register_write_mask,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    input  logic [2*REGISTERS-1:0]          i_register_status
);

    localparam int AW         = LOCAL_ADDRESS_WIDTH;
    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter value seen in the last permitted ACCESS cycle; unused when the timeout is disabled.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  next_state;

    logic [REGISTERS-1:0]    select_q;
    logic                    write_q;
    logic                    read_q;
    logic [DATA_WIDTH-1:0]   write_data_q;
    logic [DATA_WIDTH-1:0]   write_mask_q;
    logic [CW-1:0]           count_q;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic [1:0]              status_q;

    logic [AW-1:0]           word_index;
    logic                    index_hit;
    logic                    command_hit;
    logic [REGISTERS-1:0]    decoded_select;

    logic                    selected_ready;
    logic [DATA_WIDTH-1:0]   selected_data;
    logic [1:0]              selected_status;

    logic                    accept;
    logic                    load_response;
    logic [DATA_WIDTH-1:0]   response_data;
    logic [1:0]              response_status;

    // ------------------------------------------------------------------
    // Address decode: low byte-offset bits are dropped by the shift. The
    // compare is one bit wider so REGISTERS == 2**AW still decodes.
    // ------------------------------------------------------------------
    assign word_index  = i_address >> WORD_SHIFT;
    assign index_hit   = ({1'b0, word_index} < (AW + 1)'(REGISTERS));
    assign command_hit = index_hit && (i_write ^ i_read);

    always_comb begin
        decoded_select = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            decoded_select[i] = (word_index == AW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Selected register's completion. select_q is one-hot (or zero), so
    // OR-ing the masked slices is a mux; other registers' ready is ignored.
    // ------------------------------------------------------------------
    assign selected_ready = |(i_register_ready & select_q);

    always_comb begin
        selected_data   = '0;
        selected_status = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (select_q[i]) begin
                selected_data   = selected_data   | i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
                selected_status = selected_status | i_register_status[2*i +: 2];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and response source. Ready is tested before the
    // timeout so a ready arriving in the last permitted cycle still wins.
    // ------------------------------------------------------------------
    always_comb begin
        next_state      = state_q;
        accept          = 1'b0;
        load_response   = 1'b0;
        response_data   = '0;
        response_status = 2'b00;
        case (state_q)
            IDLE: begin
                if (i_command_valid) begin
                    if (command_hit) begin
                        accept     = 1'b1;
                        next_state = ACCESS;
                    end else begin
                        load_response   = 1'b1;
                        response_status = 2'b01;
                        next_state      = RESPOND;
                    end
                end
            end
            ACCESS: begin
                if (selected_ready) begin
                    load_response   = 1'b1;
                    response_data   = read_q ? selected_data : '0;
                    response_status = selected_status;
                    next_state      = RESPOND;
                end else if ((TIMEOUT_CYCLES != 0) && (count_q == TIMEOUT_LAST)) begin
                    load_response   = 1'b1;
                    response_status = 2'b01;
                    next_state      = RESPOND;
                end
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register-side command latch and timeout counter. Everything here is
    // non-zero only while in ACCESS, so it drives the outputs directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_q     <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            write_data_q <= '0;
            write_mask_q <= '0;
            count_q      <= '0;
        end else if (accept) begin
            select_q     <= decoded_select;
            write_q      <= i_write;
            read_q       <= i_read;
            write_data_q <= i_write_data;
            write_mask_q <= i_write_mask;
            count_q      <= '0;
        end else if (state_q == ACCESS) begin
            if (next_state != ACCESS) begin
                select_q     <= '0;
                write_q      <= 1'b0;
                read_q       <= 1'b0;
                write_data_q <= '0;
                write_mask_q <= '0;
                count_q      <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers: loaded on entry to RESPOND, cleared on exit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
            status_q    <= 2'b00;
        end else if (load_response) begin
            read_data_q <= response_data;
            status_q    <= response_status;
        end else if (state_q == RESPOND) begin
            read_data_q <= '0;
            status_q    <= 2'b00;
        end
    end

    assign o_response_ready      = (state_q == RESPOND);
    assign o_read_data           = read_data_q;
    assign o_status              = status_q;
    assign o_register_select     = select_q;
    assign o_register_write      = write_q;
    assign o_register_read       = read_q;
    assign o_register_write_data = write_data_q;
    assign o_register_write_mask = write_mask_q;

endmodule

// File: tb/tb_rggen_local_bus_splitter.sv
// Purpose: self-checking bench for rggen_local_bus_splitter with a scoreboard of expected responses.
// Latency: expected response cycle is computed per command from the register ready model.
// Backpressure: the bench plays the host (valid held until response) and the register side (ready on a chosen cycle).
module tb_rggen_local_bus_splitter;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NR  = 4;
    localparam int TMO = 8;

    logic             clk;
    logic             rst_n;
    logic             i_command_valid;
    logic             i_write;
    logic             i_read;
    logic [AW-1:0]    i_address;
    logic [DW-1:0]    i_write_data;
    logic [DW-1:0]    i_write_mask;
    logic             o_response_ready;
    logic [DW-1:0]    o_read_data;
    logic [1:0]       o_status;
    logic [NR-1:0]    o_register_select;
    logic             o_register_write;
    logic             o_register_read;
    logic [DW-1:0]    o_register_write_data;
    logic [DW-1:0]    o_register_write_mask;
    logic [NR-1:0]    i_register_ready;
    logic [NR*DW-1:0] i_register_read_data;
    logic [2*NR-1:0]  i_register_status;

    rggen_local_bus_splitter #(
        .DATA_WIDTH          (DW),
        .LOCAL_ADDRESS_WIDTH (AW),
        .REGISTERS           (NR),
        .TIMEOUT_CYCLES      (TMO)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_command_valid       (i_command_valid),
        .i_write               (i_write),
        .i_read                (i_read),
        .i_address             (i_address),
        .i_write_data          (i_write_data),
        .i_write_mask          (i_write_mask),
        .o_response_ready      (o_response_ready),
        .o_read_data           (o_read_data),
        .o_status              (o_status),
        .o_register_select     (o_register_select),
        .o_register_write      (o_register_write),
        .o_register_read       (o_register_read),
        .o_register_write_data (o_register_write_data),
        .o_register_write_mask (o_register_write_mask),
        .i_register_ready      (i_register_ready),
        .i_register_read_data  (i_register_read_data),
        .i_register_status     (i_register_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    status;
        int            latency;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"}, {63'd0, o_response_ready}, 64'd0);
        check({tag, "_rdata_status"}, {30'd0, o_read_data, o_status}, 64'd0);
        check({tag, "_sel_wr_rd"}, {58'd0, o_register_select, o_register_write, o_register_read}, 64'd0);
        check({tag, "_wdata_wmask"}, {o_register_write_data, o_register_write_mask}, 64'd0);
    endtask

    // One host command. ready_at = ACCESS cycle (1-based) on which the addressed register
    // raises ready, 0 = never. noise raises the ready of every other register throughout.
    // reset_at != 0 pulses rst_n in that ACCESS cycle instead of waiting for a response.
    task automatic do_cmd(input string name, input logic wr, input logic rd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] wmask, input int ready_at,
                          input logic [DW-1:0] rdata, input logic [1:0] rstatus, input logic noise,
                          input int reset_at);
        int            idx;
        logic          hit;
        logic [NR-1:0] onehot;
        logic [NR-1:0] noise_rdy;
        exp_t          e;
        int            k;
        int            sel_cycles;
        logic          got_resp;

        idx    = int'(addr >> 2);
        hit    = (idx < NR) && (wr ^ rd);
        onehot = hit ? NR'(1 << idx) : '0;
        noise_rdy = noise ? ~onehot : '0;

        // Model of the expected response.
        if (!hit) begin
            e.data = '0; e.status = 2'b01; e.latency = 1;
        end else if (ready_at >= 1 && ready_at <= TMO) begin
            e.data = rd ? rdata : '0; e.status = rstatus; e.latency = ready_at + 1;
        end else begin
            e.data = '0; e.status = 2'b01; e.latency = TMO + 1;
        end
        sb.push_back(e);

        // Register side: addressed register gets the real data, others get distinct junk.
        for (int i = 0; i < NR; i++) begin
            i_register_read_data[i*DW +: DW] = (hit && i == idx) ? rdata : (32'hDEAD_0000 | 32'(i));
            i_register_status[2*i +: 2]      = (hit && i == idx) ? rstatus : 2'b11;
        end
        i_register_ready = noise_rdy;

        i_write         = wr;
        i_read          = rd;
        i_address       = addr;
        i_write_data    = wdata;
        i_write_mask    = wmask;
        i_command_valid = 1'b1;

        k          = 0;
        sel_cycles = 0;
        got_resp   = 1'b0;
        while (!got_resp && k < 40) begin
            @(negedge clk);
            k++;
            i_register_ready = noise_rdy;
            if (o_register_select != '0) begin
                sel_cycles++;
                check({name, "_select"}, 64'(o_register_select), 64'(onehot));
                check({name, "_wr_rd"}, {62'd0, o_register_write, o_register_read}, {62'd0, wr, rd});
                check({name, "_wdata"}, 64'(o_register_write_data), 64'(wdata));
                check({name, "_wmask"}, 64'(o_register_write_mask), 64'(wmask));
                if (reset_at != 0 && sel_cycles == reset_at) begin
                    #2 rst_n = 1'b0;
                    #1 check_all_zero({name, "_async_rst"});
                    i_command_valid  = 1'b0;
                    i_register_ready = '0;
                    void'(sb.pop_front());
                    @(negedge clk);
                    check_all_zero({name, "_in_rst"});
                    rst_n = 1'b1;
                    @(negedge clk);
                    check_all_zero({name, "_after_rst"});
                    return;
                end
                if (sel_cycles == ready_at) i_register_ready = noise_rdy | onehot;
            end
            if (o_response_ready) begin
                got_resp = 1'b1;
                e = sb.pop_front();
                check({name, "_latency"}, 64'(k), 64'(e.latency));
                check({name, "_sel_cycles"}, 64'(sel_cycles), 64'(e.latency - 1));
                check({name, "_rdata"}, 64'(o_read_data), 64'(e.data));
                check({name, "_status"}, 64'(o_status), 64'(e.status));
                // Host drops the command the cycle after it sees the response.
                i_command_valid  = 1'b0;
                i_register_ready = '0;
            end
        end
        check({name, "_resp_seen"}, {63'd0, got_resp}, 64'd1);
        if (!got_resp) i_command_valid = 1'b0;
        @(negedge clk);
        // Back in IDLE: one-cycle strobe, cleared response, no re-acceptance.
        check_all_zero({name, "_idle"});
    endtask

    initial begin
        n_checks             = 0;
        n_errors             = 0;
        rst_n                = 1'b0;
        i_command_valid      = 1'b0;
        i_write              = 1'b0;
        i_read               = 1'b0;
        i_address            = '0;
        i_write_data         = '0;
        i_write_mask         = '0;
        i_register_ready     = '0;
        i_register_read_data = '0;
        i_register_status    = '0;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        //        name        wr    rd    addr     wdata          wmask          rdy  rdata          rst    noise reset
        do_cmd("wr_reg1",   1'b1, 1'b0, 16'h0004, 32'hA5A5_0000, 32'hFFFF_0000, 3,  32'h0BAD_BEEF, 2'b00, 1'b0, 0);
        do_cmd("rd_reg3",   1'b0, 1'b1, 16'h000C, 32'h0,         32'h0,         1,  32'h1234_5678, 2'b00, 1'b0, 0);
        do_cmd("rd_miss",   1'b0, 1'b1, 16'h0010, 32'h0,         32'h0,         1,  32'h1111_1111, 2'b00, 1'b0, 0);
        do_cmd("rd_tmo",    1'b0, 1'b1, 16'h0000, 32'h0,         32'h0,         0,  32'h2222_2222, 2'b00, 1'b0, 0);
        do_cmd("rd_last",   1'b0, 1'b1, 16'h0000, 32'h0,         32'h0,         8,  32'hCAFE_F00D, 2'b00, 1'b0, 0);
        do_cmd("wr_err",    1'b1, 1'b0, 16'h0009, 32'h0F0F_0F0F, 32'h00FF_00FF, 2,  32'h3333_3333, 2'b01, 1'b1, 0);
        do_cmd("rd_noise",  1'b0, 1'b1, 16'h0006, 32'h0,         32'h0,         4,  32'h89AB_CDEF, 2'b00, 1'b1, 0);
        do_cmd("both_miss", 1'b1, 1'b1, 16'h0004, 32'h5555_5555, 32'hFFFF_FFFF, 1,  32'h4444_4444, 2'b00, 1'b0, 0);
        do_cmd("none_miss", 1'b0, 1'b0, 16'h0008, 32'h0,         32'h0,         1,  32'h4444_4444, 2'b00, 1'b0, 0);
        do_cmd("rd_rst",    1'b0, 1'b1, 16'h0004, 32'h0,         32'h0,         0,  32'h5555_5555, 2'b00, 1'b0, 3);
        do_cmd("rd_after",  1'b0, 1'b1, 16'h0008, 32'h0,         32'h0,         1,  32'h7654_3210, 2'b00, 1'b0, 0);

        for (int t = 0; t < 4; t++) begin
            automatic int a  = int'($urandom_range(0, 5));
            automatic int r  = int'($urandom_range(0, 10));
            automatic logic [DW-1:0] d = $urandom;
            do_cmd("rand", 1'b0, 1'b1, AW'(a * 4), 32'h0, 32'h0, r, d, 2'b00, 1'b1, 0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
